// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline types: matrix element width, 4x4 matrix type,
// the chain-sequencer state encoding and the 16.16 fixed-point one.
package gfx_pkg;

  localparam int MAT_WIDTH = 32;

  typedef logic signed [3:0][3:0][MAT_WIDTH-1:0] mat4_t;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    ISSUE,
    WAIT_DONE,
    OUTPUT,
    ERROR
  } seq_state_t;

  localparam logic [31:0] FP_ONE = 32'h0001_0000;

endpackage

// File: rtl/cycle_watchdog.sv
// Cycle counter that flags when LIMIT cycles have elapsed since the last clear.
module cycle_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] wdog;

  // expired is high on the LIMIT-th enabled cycle after a clear
  assign expired = (wdog == CW'(LIMIT - 1));

  // count enabled cycles, parking at the limit until cleared
  always_ff @(posedge clk_in) begin
    if (rst_in || clear) wdog <= '0;
    else if (enable && !expired) wdog <= wdog + CW'(1);
  end

endmodule

// File: rtl/matrix_chain_sequencer.sv
// Folds a stream of 4x4 matrices into one product, left to right, by driving
// an external multiplier through its start/busy/done handshake.
module matrix_chain_sequencer
  import gfx_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int MAX_MATS       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0][3:0][WIDTH-1:0]   in_mat,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0][3:0][WIDTH-1:0]   out_mat,
  output logic                         mul_start,
  output logic [3:0][3:0][WIDTH-1:0]   mul_m1,
  output logic [3:0][3:0][WIDTH-1:0]   mul_m2,
  input  logic                         mul_busy,
  input  logic                         mul_done,
  input  logic [3:0][3:0][WIDTH-1:0]   mul_result,
  output logic                         err,
  output logic                         overflow
);

  localparam int CW = $clog2(MAX_MATS + 1);

  seq_state_t                 state, state_nxt;
  logic [3:0][3:0][WIDTH-1:0] acc;
  logic [CW-1:0]              cnt;
  logic                       last_q;
  logic                       wd_exp;
  logic                       in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  cycle_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear   (state != WAIT_DONE),
    .enable  (state == WAIT_DONE),
    .expired (wd_exp)
  );

  // state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state: mul_done beats a coincident timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (in_xfer) state_nxt = in_last ? OUTPUT : COLLECT;
      COLLECT:   if (in_xfer) state_nxt = ISSUE;
      ISSUE:     if (!mul_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (mul_done)    state_nxt = last_q ? OUTPUT : COLLECT;
        else if (wd_exp) state_nxt = ERROR;
      end
      OUTPUT:    if (out_xfer) state_nxt = IDLE;
      ERROR:     state_nxt = ERROR;
      default:   state_nxt = IDLE;
    endcase
  end

  // registered outputs and datapath; operands only move on a COLLECT accept,
  // so they stay put from mul_start through mul_done
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      mul_start <= 1'b0;
      err       <= 1'b0;
      overflow  <= 1'b0;
      out_mat   <= '0;
      mul_m1    <= '0;
      mul_m2    <= '0;
      acc       <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE) || (state_nxt == COLLECT);
      out_valid <= (state == OUTPUT) && (state_nxt == OUTPUT);
      mul_start <= (state == ISSUE) && !mul_busy;
      if (state == OUTPUT) out_mat <= acc;
      case (state)
        IDLE: if (in_xfer) begin
          acc <= in_mat;
          cnt <= CW'(1);
        end
        COLLECT: if (in_xfer) begin
          mul_m1 <= acc;
          mul_m2 <= in_mat;
          cnt    <= cnt + CW'(1);
          last_q <= in_last;
          if ((cnt + CW'(1)) == CW'(MAX_MATS) && !in_last) begin
            last_q   <= 1'b1;
            overflow <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (mul_done)    acc <= mul_result;
          else if (wd_exp) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_chain_sequencer.sv
// Directed bench: two sequencer instances (MAX_MATS=8 and MAX_MATS=2, both with
// a 16-cycle watchdog) share stimulus and a 16.16 multiplier model whose
// latency, busy and done behaviour the stimulus controls.
module tb_matrix_chain_sequencer;
  import gfx_pkg::*;

  typedef logic [3:0][3:0][31:0] m_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  m_t   in_mat = '0;

  logic a_in_ready, a_out_valid, a_mul_start, a_err, a_overflow;
  logic b_in_ready, b_out_valid, b_mul_start, b_err, b_overflow;
  m_t   a_out_mat, a_m1, a_m2, b_out_mat, b_m1, b_m2;

  // multiplier model state
  logic busy_m = 1'b0, done_m = 1'b0, busy_force = 1'b0;
  logic hang = 1'b0, kill = 1'b0;
  int   lat = 9, cnt_m = 0;
  m_t   res_m = '0;
  logic mul_busy;
  assign mul_busy = busy_m | busy_force;

  logic sel = 1'b0;
  logic s_in_ready, s_out_valid, s_mul_start, s_err, s_overflow;
  m_t   s_out_mat, s_m1, s_m2;
  assign s_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign s_out_valid = sel ? b_out_valid : a_out_valid;
  assign s_mul_start = sel ? b_mul_start : a_mul_start;
  assign s_err       = sel ? b_err       : a_err;
  assign s_overflow  = sel ? b_overflow  : a_overflow;
  assign s_out_mat   = sel ? b_out_mat   : a_out_mat;
  assign s_m1        = sel ? b_m1        : a_m1;
  assign s_m2        = sel ? b_m2        : a_m2;

  matrix_chain_sequencer #(.WIDTH(32), .MAX_MATS(8), .TIMEOUT_CYCLES(16)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_mat(in_mat), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_mat(a_out_mat), .mul_start(a_mul_start), .mul_m1(a_m1), .mul_m2(a_m2),
    .mul_busy(mul_busy), .mul_done(done_m), .mul_result(res_m), .err(a_err),
    .overflow(a_overflow));

  matrix_chain_sequencer #(.WIDTH(32), .MAX_MATS(2), .TIMEOUT_CYCLES(16)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_mat(in_mat), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_mat(b_out_mat), .mul_start(b_mul_start), .mul_m1(b_m1), .mul_m2(b_m2),
    .mul_busy(mul_busy), .mul_done(done_m), .mul_result(res_m), .err(b_err),
    .overflow(b_overflow));

  function automatic m_t fmul(input m_t a, input m_t b);
    m_t r;
    longint s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += longint'($signed(a[i][k])) * longint'($signed(b[k][j]));
        r[i][j] = s[47:16];
      end
    return r;
  endfunction

  // multiplier model; deliberately ignores rst_in so a stale done can arrive
  always @(posedge clk_in) begin
    done_m <= 1'b0;
    if (kill) busy_m <= 1'b0;
    else if (s_mul_start && !busy_m) begin
      busy_m <= 1'b1;
      cnt_m  <= lat;
      res_m  <= fmul(s_m1, s_m2);
    end else if (busy_m) begin
      if (cnt_m > 1) cnt_m <= cnt_m - 1;
      else if (!hang) begin
        busy_m <= 1'b0;
        done_m <= 1'b1;
      end
    end
  end

  int n_start = 0;
  always @(posedge clk_in) n_start <= n_start + int'(s_mul_start);

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    tick();
  endtask

  function automatic m_t diag(input logic [31:0] v);
    m_t r = '0;
    for (int i = 0; i < 4; i++) r[i][i] = v;
    return r;
  endfunction

  task automatic send(input m_t m, input logic last);
    logic ok, r;
    ok = 1'b0;
    in_valid = 1'b1;
    in_mat   = m;
    in_last  = last;
    for (int i = 0; i < 200; i++) begin
      r = s_in_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_out(input string tag);
    for (int i = 0; i < 200 && !s_out_valid; i++) tick();
    check(tag, s_out_valid, 1'b1);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_low"}, s_out_valid, 1'b0);
    check({tag, "_ready"}, s_in_ready, 1'b1);
  endtask

  m_t ma, mb, mc, mexp;
  int base;

  initial begin
    // reset state, sampled while rst_in is still high
    tick();
    tick();
    check("rst_in_ready", a_in_ready, 1'b0);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_mul_start", a_mul_start, 1'b0);
    check("rst_err", a_err, 1'b0);
    check("rst_overflow", a_overflow, 1'b0);
    check("rst_out_mat", a_out_mat, '0);
    check("rst_m1", a_m1, '0);
    rst_in = 1'b0;
    tick();
    check("idle_ready", a_in_ready, 1'b1);

    // T1: single matrix passes straight through
    base = n_start;
    send(diag(FP_ONE * 5), 1'b1);
    check("t1_ov_early", s_out_valid, 1'b0);
    check("t1_ready_low", s_in_ready, 1'b0);
    tick();
    check("t1_ov", s_out_valid, 1'b1);
    check("t1_mat", s_out_mat, diag(32'h0005_0000));
    check("t1_nostart", n_start - base, 0);
    accept("t1");

    // T2: two diagonal matrices, one multiply
    base = n_start;
    lat  = 9;
    send(diag(32'h0002_0000), 1'b0);
    send(diag(32'h0003_0000), 1'b1);
    wait_out("t2_ov");
    check("t2_mat", s_out_mat, diag(32'h0006_0000));
    check("t2_starts", n_start - base, 1);
    accept("t2");

    // T3: three-matrix chain with output back-pressure
    ma = diag(FP_ONE); ma[0][1] = 32'h0002_0000;
    mb = diag(32'h0002_0000);
    mc = diag(FP_ONE); mc[1][0] = 32'h0003_0000;
    mexp = diag(32'h0002_0000);
    mexp[0][0] = 32'h000E_0000; mexp[0][1] = 32'h0004_0000;
    mexp[1][0] = 32'h0006_0000; mexp[1][1] = 32'h0002_0000;
    base = n_start;
    send(ma, 1'b0);
    send(mb, 1'b0);
    send(mc, 1'b1);
    wait_out("t3_ov");
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_ov", s_out_valid, 1'b1);
      check("t3_hold_mat", s_out_mat, mexp);
      check("t3_hold_ready", s_in_ready, 1'b0);
      tick();
    end
    check("t3_starts", n_start - base, 2);
    accept("t3");

    // T4: multiplier busy stalls the start pulse
    lat = 3;
    base = n_start;
    send(diag(32'h0002_0000), 1'b0);
    busy_force = 1'b1;
    send(diag(32'h0004_0000), 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_stall", s_mul_start, 1'b0);
    end
    busy_force = 1'b0;
    tick();
    check("t4_start", s_mul_start, 1'b1);
    check("t4_m1", s_m1, diag(32'h0002_0000));
    check("t4_m2", s_m2, diag(32'h0004_0000));
    tick();
    check("t4_pulse_end", s_mul_start, 1'b0);
    wait_out("t4_ov");
    check("t4_mat", s_out_mat, diag(32'h0008_0000));
    check("t4_starts", n_start - base, 1);
    accept("t4");

    // T5: done never arrives, watchdog trips after 16 WAIT_DONE cycles
    hang = 1'b1;
    send(diag(FP_ONE), 1'b0);
    send(diag(FP_ONE), 1'b1);
    for (int i = 0; i < 16; i++) tick();
    check("t5_err_early", s_err, 1'b0);
    tick();
    check("t5_err", s_err, 1'b1);
    check("t5_ready", s_in_ready, 1'b0);
    check("t5_ov", s_out_valid, 1'b0);
    tick();
    tick();
    check("t5_err_sticky", s_err, 1'b1);
    kill = 1'b1;
    hang = 1'b0;
    do_reset();
    kill = 1'b0;
    check("t5_err_clr", s_err, 1'b0);
    check("t5_ready_back", s_in_ready, 1'b1);

    // T6: MAX_MATS=2 overflow and a stale done after reset
    sel = 1'b1;
    lat = 3;
    do_reset();
    send(diag(32'h0002_0000), 1'b0);
    check("t6_no_ovf", s_overflow, 1'b0);
    send(diag(32'h0003_0000), 1'b0);
    check("t6_ovf", s_overflow, 1'b1);
    wait_out("t6_ov");
    check("t6_mat", s_out_mat, diag(32'h0006_0000));
    check("t6_err", s_err, 1'b0);
    accept("t6");
    lat = 6;
    send(diag(32'h0005_0000), 1'b0);
    check("t6_ovf_sticky", s_overflow, 1'b1);
    send(diag(32'h0002_0000), 1'b0);
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    check("t6_stale_ov", s_out_valid, 1'b0);
    check("t6_stale_ready", s_in_ready, 1'b1);
    check("t6_ovf_clr", s_overflow, 1'b0);
    send(diag(32'h0007_0000), 1'b1);
    wait_out("t6_post_ov");
    check("t6_post_mat", s_out_mat, diag(32'h0007_0000));
    accept("t6_post");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
